// File: rtl/hdlc_rx_drain_pkg.sv
// Shared definitions for the Hdlc receive drain: FSM states, Hdlc register
// map, status bit positions, drop command and error codes.
package hdlc_rx_drain_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_STAT,
    W_STAT,
    RD_LEN,
    W_LEN,
    RD_BYTE,
    W_BYTE,
    PUSH,
    DROP,
    DONE
  } state_t;

  // Hdlc register addresses
  localparam logic [2:0] RX_SC   = 3'h2;
  localparam logic [2:0] RX_BUFF = 3'h3;
  localparam logic [2:0] RX_LEN  = 3'h4;

  // RX_SC bit positions
  localparam int SC_DROP_BIT      = 1;
  localparam int SC_FRAME_ERR_BIT = 2;
  localparam int SC_ABORT_BIT     = 3;
  localparam int SC_OVERFLOW_BIT  = 4;

  // Writing this to RX_SC discards the current Rx frame
  localparam logic [7:0] DROP_CMD   = 8'h02;
  localparam logic [2:0] ERR_BADLEN = 3'b111;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hdlc_rx_drain_bus_rd.sv
// Single read transaction on the Hdlc register bus: pulses the read strobe
// when started, holds the address through the read latency and flags the
// cycle in which read data is valid (RD_LAT cycles after the strobe).
module hdlc_bus_rd #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] addr,
  input  logic [7:0] bus_rdata,
  output logic [2:0] bus_addr,
  output logic       rd_en,
  output logic [7:0] rdata,
  output logic       done
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  logic       busy_q, busy_d;
  logic [1:0] lat_q, lat_d;
  logic [2:0] addr_q, addr_d;

  // Latency countdown: loaded on start, done when it reaches zero
  always_comb begin
    busy_d = busy_q;
    lat_d  = lat_q;
    addr_d = addr_q;
    if (start) begin
      busy_d = 1'b1;
      lat_d  = LAT_INIT;
      addr_d = addr;
    end else if (busy_q) begin
      if (lat_q == 2'd0) begin
        busy_d = 1'b0;
      end else begin
        lat_d = lat_q - 2'd1;
      end
    end
  end

  // Transaction state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      lat_q  <= 2'd0;
      addr_q <= 3'd0;
    end else begin
      busy_q <= busy_d;
      lat_q  <= lat_d;
      addr_q <= addr_d;
    end
  end

  // Strobe passes straight through so the address appears with it
  always_comb begin
    rd_en    = start;
    bus_addr = start ? addr : addr_q;
    rdata    = bus_rdata;
    done     = busy_q && (lat_q == 2'd0);
  end

endmodule

// File: rtl/hdlc_rx_drain.sv
// Drains received Hdlc frames onto a valid/ready byte stream. Reads RX_SC,
// then RX_LEN, then each byte from RX_BUFF; bad frames are dropped by
// writing DROP_CMD to RX_SC and reported with frame_err/err_code.
// Optional: define HDLC_RX_DRAIN_STATS_EN for saturating good/drop counters.
module hdlc_rx_drain
  import hdlc_rx_drain_pkg::*;
#(
  parameter int MAX_LEN = 126,
  parameter int RD_LAT  = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Rx_Ready,
  output logic [2:0]  Address,
  output logic        ReadEnable,
  output logic        WriteEnable,
  output logic [7:0]  DataIn,
  input  logic [7:0]  DataOut,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_done,
  output logic        frame_err,
`ifdef HDLC_RX_DRAIN_STATS_EN
  output logic [15:0] stat_ok,
  output logic [15:0] stat_drop,
`endif
  output logic [2:0]  err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [6:0] len_q, len_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] err_q, err_d;

  logic       rd_start;
  logic [2:0] rd_addr;
  logic [2:0] rd_bus_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_done;
  logic       last_beat;

  hdlc_bus_rd #(
    .RD_LAT(RD_LAT)
  ) u_bus_rd (
    .clk      (Clk),
    .rst      (Rst),
    .start    (rd_start),
    .addr     (rd_addr),
    .bus_rdata(DataOut),
    .bus_addr (rd_bus_addr),
    .rd_en    (rd_en),
    .rdata    (rd_data),
    .done     (rd_done)
  );

  assign last_beat = (cnt_q == (len_q - 7'd1));

  // Next-state logic: status check, length check, then byte-by-byte drain
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    err_d    = err_q;
    rd_start = 1'b0;
    rd_addr  = RX_SC;
    case (state_q)
      IDLE: begin
        if (Rx_Ready) state_d = RD_STAT;
      end
      RD_STAT: begin
        rd_start = 1'b1;
        rd_addr  = RX_SC;
        state_d  = W_STAT;
      end
      W_STAT: begin
        if (rd_done) begin
          if (|rd_data[SC_OVERFLOW_BIT:SC_FRAME_ERR_BIT]) begin
            err_d   = rd_data[SC_OVERFLOW_BIT:SC_FRAME_ERR_BIT];
            state_d = DROP;
          end else begin
            state_d = RD_LEN;
          end
        end
      end
      RD_LEN: begin
        rd_start = 1'b1;
        rd_addr  = RX_LEN;
        state_d  = W_LEN;
      end
      W_LEN: begin
        if (rd_done) begin
          // Compare all 8 bits so oversize lengths cannot alias into range
          if ((rd_data == 8'd0) || (rd_data > MAX_LEN_B)) begin
            err_d   = ERR_BADLEN;
            state_d = DROP;
          end else begin
            len_d   = rd_data[6:0];
            cnt_d   = 7'd0;
            state_d = RD_BYTE;
          end
        end
      end
      RD_BYTE: begin
        rd_start = 1'b1;
        rd_addr  = RX_BUFF;
        state_d  = W_BYTE;
      end
      W_BYTE: begin
        if (rd_done) begin
          byte_d  = rd_data;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (m_ready) begin
          cnt_d   = cnt_q + 7'd1;
          state_d = last_beat ? DONE : RD_BYTE;
        end
      end
      DROP:    state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and frame registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      len_q   <= 7'd0;
      cnt_q   <= 7'd0;
      byte_q  <= 8'd0;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from the registered state so they clear with reset
  always_comb begin
    m_valid     = (state_q == PUSH);
    m_data      = byte_q;
    m_last      = m_valid && last_beat;
    frame_done  = (state_q == DONE);
    frame_err   = (state_q == DROP);
    err_code    = frame_err ? err_q : 3'd0;
    WriteEnable = frame_err;
    DataIn      = frame_err ? DROP_CMD : 8'd0;
    ReadEnable  = rd_en;
    Address     = frame_err ? RX_SC : rd_bus_addr;
  end

`ifdef HDLC_RX_DRAIN_STATS_EN
  logic [15:0] stat_ok_q, stat_ok_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  // Saturating frame counters
  always_comb begin
    stat_ok_d   = frame_done ? sat_inc(stat_ok_q) : stat_ok_q;
    stat_drop_d = frame_err ? sat_inc(stat_drop_q) : stat_drop_q;
  end

  // Counter registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stat_ok_q   <= 16'd0;
      stat_drop_q <= 16'd0;
    end else begin
      stat_ok_q   <= stat_ok_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_ok   = stat_ok_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_hdlc_rx_drain.sv
// Bench for hdlc_rx_drain: behavioural Hdlc register model plus a
// scoreboard of expected stream beats and frame_done/frame_err events.
module tb_hdlc_rx_drain;

  localparam int RD_LAT  = 2;
  localparam int MAX_LEN = 126;

  logic        Clk;
  logic        Rst;
  logic        Rx_Ready;
  logic [2:0]  Address;
  logic        ReadEnable;
  logic        WriteEnable;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;
`ifdef HDLC_RX_DRAIN_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_drop;
`endif

  hdlc_rx_drain #(
    .MAX_LEN(MAX_LEN),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Rx_Ready   (Rx_Ready),
    .Address    (Address),
    .ReadEnable (ReadEnable),
    .WriteEnable(WriteEnable),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
`ifdef HDLC_RX_DRAIN_STATS_EN
    .stat_ok    (stat_ok),
    .stat_drop  (stat_drop),
`endif
    .err_code   (err_code)
  );

  typedef struct {
    logic [7:0] status;
    logic [7:0] len;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    bit         toggle;
    bit         exp_err;
    logic [2:0] exp_code;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Hdlc model state
  logic [7:0] hdlc_status;
  logic [7:0] hdlc_len;
  logic [7:0] buff[$];
  logic [7:0] pipe[RD_LAT];
  int n_sc, n_len, n_buff, n_wr;

  // Scoreboard: beats are {last, data}; events are {err, done, code}
  logic [8:0] exp_beats[$];
  logic [4:0] exp_evt[$];
  int exp_ok, exp_drop;

  // Stream monitor state
  bit         ready_toggle;
  bit         prev_valid, prev_ready, prev_last;
  logic [7:0] prev_data;
  int         cyc, last_beat_cyc, beat_idx;

  vec_t vecs[10];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] frameByte(input vec_t v, input int i);
    case (i)
      0:       return v.b0;
      1:       return v.b1;
      2:       return v.b2;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // One clock: drive inputs, serve the Hdlc bus, check the stream at negedge
  task automatic stepCycle();
    logic [7:0] v;
    logic [8:0] e;
    logic [4:0] ev;
    @(negedge Clk);
    cyc++;
    m_ready = ready_toggle ? ~m_ready : 1'b1;
    DataOut = pipe[RD_LAT-1];
    for (int k = RD_LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
    v = 8'hEE;
    if (!Rst && ReadEnable) begin
      case (Address)
        3'h2: begin v = hdlc_status; n_sc++; Rx_Ready = 1'b0; end
        3'h4: begin v = hdlc_len; n_len++; end
        3'h3: begin n_buff++; if (buff.size() > 0) v = buff.pop_front(); end
        default: checkOutput("rd_addr", 32'(Address), 32'h3);
      endcase
    end
    pipe[0] = v;
    if (Rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (ReadEnable && WriteEnable) checkOutput("rd_wr_excl", 1, 0);
      if (WriteEnable) begin
        n_wr++;
        checkOutput("wr_addr", 32'(Address), 32'h2);
        checkOutput("wr_data", 32'(DataIn), 32'h02);
      end
      if (m_valid) begin
        if (ReadEnable) checkOutput("rd_during_push", 1, 0);
        if (prev_valid && !prev_ready) begin
          checkOutput("stall_data", 32'(m_data), 32'(prev_data));
          checkOutput("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (m_ready) begin
          if (exp_beats.size() == 0) begin
            checkOutput("unexpected_beat", 1, 0);
          end else begin
            e = exp_beats.pop_front();
            checkOutput("beat_data", 32'(m_data), 32'(e[7:0]));
            checkOutput("beat_last", 32'(m_last), 32'(e[8]));
          end
          if (!ready_toggle && beat_idx > 0)
            checkOutput("beat_period", cyc - last_beat_cyc, RD_LAT + 2);
          last_beat_cyc = cyc;
          beat_idx++;
        end
      end else if (prev_valid && !prev_ready) begin
        checkOutput("valid_dropped", 0, 1);
      end
      if (frame_done || frame_err) begin
        if (exp_evt.size() == 0) begin
          checkOutput("unexpected_evt", {frame_err, frame_done, err_code}, 0);
        end else begin
          ev = exp_evt.pop_front();
          checkOutput("frame_evt", {frame_err, frame_done, frame_err ? err_code : 3'b000}, 32'(ev));
        end
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  endtask

  // Load the Hdlc model with a frame and queue the expected results
  task automatic loadFrame(input vec_t v);
    hdlc_status = v.status;
    hdlc_len    = v.len;
    buff.delete();
    for (int i = 0; i < int'(v.len); i++) buff.push_back(frameByte(v, i));
    if (v.exp_err) begin
      exp_evt.push_back({2'b10, v.exp_code});
      exp_drop++;
    end else begin
      for (int i = 0; i < int'(v.len); i++)
        exp_beats.push_back({i == int'(v.len) - 1, frameByte(v, i)});
      exp_evt.push_back(5'b01000);
      exp_ok++;
    end
    ready_toggle = v.toggle;
    m_ready      = 1'b1;
    beat_idx     = 0;
    Rx_Ready     = 1'b1;
  endtask

  // Run one complete frame and check the bus traffic it caused
  task automatic applyStimulus(input vec_t v);
    int sc0, len0, bf0, wr0;
    bit fin;
    sc0 = n_sc; len0 = n_len; bf0 = n_buff; wr0 = n_wr;
    fin = 1'b0;
    loadFrame(v);
    for (int i = 0; i < 3000 && !fin; i++) begin
      stepCycle();
      if (exp_evt.size() == 0) fin = 1'b1;
    end
    checkOutput("frame_timeout", 32'(fin), 1);
    repeat (4) stepCycle();
    checkOutput("beats_left", exp_beats.size(), 0);
    checkOutput("sc_reads", n_sc - sc0, 1);
    checkOutput("len_reads", n_len - len0, (v.status[4:2] == 3'b000) ? 1 : 0);
    checkOutput("buff_reads", n_buff - bf0, v.exp_err ? 0 : int'(v.len));
    checkOutput("writes", n_wr - wr0, v.exp_err ? 1 : 0);
    exp_beats.delete();
    exp_evt.delete();
  endtask

  initial begin
    vec_t rv;
    bit   hit;
    int   wr0;
    vecs[0] = '{8'h01, 8'd3,   8'hA5, 8'h0F, 8'h81, 1'b0, 1'b0, 3'b000};
    vecs[1] = '{8'h00, 8'd3,   8'hA5, 8'h0F, 8'h81, 1'b1, 1'b0, 3'b000};
    vecs[2] = '{8'h09, 8'd3,   8'hA5, 8'h0F, 8'h81, 1'b0, 1'b1, 3'b010};
    vecs[3] = '{8'h00, 8'd0,   8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 3'b111};
    vecs[4] = '{8'h00, 8'd127, 8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 3'b111};
    vecs[5] = '{8'h10, 8'd5,   8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 3'b100};
    vecs[6] = '{8'h04, 8'd2,   8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 3'b001};
    vecs[7] = '{8'h02, 8'd1,   8'h5A, 8'h22, 8'h33, 1'b1, 1'b0, 3'b000};
    vecs[8] = '{8'h00, 8'd126, 8'hC3, 8'h3C, 8'h99, 1'b0, 1'b0, 3'b000};
    vecs[9] = '{8'h00, 8'h83,  8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 3'b111};

    Rst = 1'b1; Rx_Ready = 1'b0; m_ready = 1'b1; DataOut = 8'hEE;
    ready_toggle = 1'b0; hdlc_status = 8'h00; hdlc_len = 8'h00;
    for (int k = 0; k < RD_LAT; k++) pipe[k] = 8'hEE;
    n_sc = 0; n_len = 0; n_buff = 0; n_wr = 0; exp_ok = 0; exp_drop = 0;
    cyc = 0; last_beat_cyc = 0; beat_idx = 0;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_data = 8'h00; prev_last = 1'b0;

    repeat (3) stepCycle();
    checkOutput("rst_m_valid", 32'(m_valid), 0);
    checkOutput("rst_m_data", 32'(m_data), 0);
    checkOutput("rst_m_last", 32'(m_last), 0);
    checkOutput("rst_strobes", {ReadEnable, WriteEnable}, 0);
    checkOutput("rst_addr_din", {Address, DataIn}, 0);
    checkOutput("rst_events", {frame_done, frame_err, err_code}, 0);
    Rst = 1'b0;
    repeat (4) stepCycle();
    checkOutput("idle_no_read", n_sc, 0);

    $display("[TB] table-driven frames");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] reset during second push");
    rv = '{8'h00, 8'd5, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 3'b000};
    loadFrame(rv);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      stepCycle();
      if (m_valid && beat_idx == 2) hit = 1'b1;
    end
    checkOutput("reach_push2", 32'(hit), 1);
    wr0 = n_wr;
    Rst = 1'b1;
    #1;
    checkOutput("arst_m_valid", 32'(m_valid), 0);
    checkOutput("arst_m_data", 32'(m_data), 0);
    checkOutput("arst_m_last", 32'(m_last), 0);
    checkOutput("arst_strobes", {ReadEnable, WriteEnable}, 0);
    exp_beats.delete();
    exp_evt.delete();
    exp_ok = 0;
    exp_drop = 0;
    repeat (3) stepCycle();
    checkOutput("arst_no_drop", n_wr - wr0, 0);
    Rx_Ready = 1'b1;
    Rst = 1'b0;
    rv = '{8'h00, 8'd2, 8'h66, 8'h77, 8'h88, 1'b0, 1'b0, 3'b000};
    applyStimulus(rv);
    rv = '{8'h00, 8'd3, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 3'b000};
    applyStimulus(rv);
    rv = '{8'h08, 8'd3, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 3'b010};
    applyStimulus(rv);

`ifdef HDLC_RX_DRAIN_STATS_EN
    checkOutput("stat_ok", 32'(stat_ok), 32'(exp_ok));
    checkOutput("stat_drop", 32'(stat_drop), 32'(exp_drop));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
